// File: rtl/fifo_rd_stream.sv
// Purpose: drains a synchronous FIFO (registered read) and presents its words as a valid/ready stream.
// Latency: fifo_rd_en in cycle N, word captured at end of N+1, m_valid in N+2; 1 word/cycle sustained.
// Backpressure: m_ready low stalls issue once 2 words are buffered; resumes with no bubble.
// Ports: clk/rstn (async active-low); fifo_empty/fifo_data in, fifo_cs/fifo_rd_en out (FIFO read port);
//        flush in (sync discard of buffered + in-flight words); m_valid/m_data/m_ready stream;
//        word_cnt out: delivered-word counter, present only with FIFO_RD_STREAM_CNT_EN defined, else 0.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [1:0]            occ_after_pop;
  logic [1:0]            pending;
  logic                  infl;
  logic                  pop;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [DATA_WIDTH-1:0] buf0_nxt;
  logic [DATA_WIDTH-1:0] buf1_nxt;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid && m_ready;

  // Occupancy after this cycle's pop; a returning word lands in the slot it names.
  assign occ_after_pop = occ - {1'b0, pop};
  // Words that will hold a slot after this edge if no new read is issued.
  assign pending       = occ_after_pop + {1'b0, infl};

  // Gated by rstn so the FIFO sees no read while reset is held; !fifo_empty
  // makes every issued read a committed one.
  assign fifo_rd_en = rstn && !fifo_empty && !flush && (pending < 2'd2);
  assign fifo_cs    = fifo_rd_en;

  always_comb begin
    occ_nxt  = occ_after_pop;
    buf0_nxt = buf0;
    buf1_nxt = buf1;
    if (pop) begin
      buf0_nxt = buf1;
    end
    if (flush) begin
      // Returning word in the flush cycle is dropped along with the buffer.
      occ_nxt = 2'd0;
    end else if (infl) begin
      if (occ_after_pop == 2'd0) begin
        buf0_nxt = fifo_data;
      end else begin
        buf1_nxt = fifo_data;
      end
      occ_nxt = occ_after_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ  <= 2'd0;
      infl <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ  <= occ_nxt;
      infl <= fifo_rd_en;
      buf0 <= buf0_nxt;
      buf1 <= buf1_nxt;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Counts every handshake, including one in a flush cycle; wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign word_cnt = cnt_q;
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Purpose: directed self-checking bench for fifo_rd_stream with a behavioural depth-8 FIFO.
// Latency: checks first-word timing, streaming, back-pressure, alternating ready, flush, counter wrap.
// Backpressure: m_ready patterns are driven per scenario; outputs sampled mid-cycle.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [3:0]  word_cnt;

  // FIFO model controls
  logic        push;
  logic [31:0] push_dat;
  logic        fclr;
  logic [31:0] fmem [8];
  logic [3:0]  fcnt;
  logic [2:0]  wp;
  logic [2:0]  rp;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;   // handshakes since the last DUT reset

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .word_cnt   (word_cnt)
  );

  // Synchronous FIFO with registered read data; cleared by fclr so the
  // reset test can hold words while the DUT is in reset.
  assign fifo_empty = (fcnt == 4'd0);

  always @(posedge clk) begin
    if (fclr) begin
      fcnt <= 4'd0;
      wp   <= 3'd0;
      rp   <= 3'd0;
    end else begin
      if (push) begin
        fmem[wp] <= push_dat;
        wp       <= wp + 3'd1;
      end
      if (fifo_rd_en && fifo_cs) begin
        fifo_data <= fmem[rp];
        rp        <= rp + 3'd1;
      end
      fcnt <= fcnt + {3'b0, push} - {3'b0, fifo_rd_en};
    end
  end

  function automatic logic [3:0] exp_cnt();
`ifdef FIFO_RD_STREAM_CNT_EN
    return pops[3:0];
`else
    return 4'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; fclr = 1'b1; push = 1'b0; push_dat = '0; flush = 1'b0; m_ready = 1'b0;
    tick();
    fclr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push = 1'b1; push_dat = 32'hA1 + c;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: m_valid=%b rd_en=%b expected 0/0", m_valid, fifo_rd_en);
      end
      tick();
    end
    push = 1'b0;
    #1;
    n_checks++;
    if (fifo_empty !== 1'b0 || fifo_rd_en !== 1'b0 || fifo_cs !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_gate: empty=%b rd_en=%b cs=%b expected 0/0/0", fifo_empty, fifo_rd_en, fifo_cs);
    end
    n_checks++;
    if (m_data !== 32'h0 || word_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_vals: m_data=%h word_cnt=%0d expected 0/0", m_data, word_cnt);
    end
    pops = 0;
    rstn = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1 || fifo_cs !== 1'b1) begin
      n_fail++; $display("FAIL first_read: rd_en=%b cs=%b expected 1/1", fifo_rd_en, fifo_cs);
    end
    m_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_n1: m_valid=%b expected 0", m_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hA1 + k) begin
        n_fail++; $display("FAIL reset_drain%0d: m_valid=%b m_data=%h expected 1/%h", k, m_valid, m_data, 32'hA1 + k);
      end
      if (m_valid && m_ready) pops++;
    end
    tick();
    n_checks++;
    if (word_cnt !== exp_cnt() || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt: word_cnt=%0d m_valid=%b expected %0d/0", word_cnt, m_valid, exp_cnt());
    end
  endtask

  task automatic test_streaming();
    int got = 0;
    bit started = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      push = (cyc < 8); push_dat = 32'h1 + cyc;
      #1;
      if (started) begin
        n_checks++;
        if (m_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_gap: m_valid=%b expected 1 at word %0d", m_valid, got);
        end
      end
      if (m_valid) begin
        started = 1'b1;
        n_checks++;
        if (m_data !== 32'h1 + got) begin
          n_fail++; $display("FAIL stream_data: got %h expected %h", m_data, 32'h1 + got);
        end
        got++; pops++;
      end
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (got != 8) begin
      n_fail++; $display("FAIL stream_timeout: delivered %0d expected 8", got);
    end
    n_checks++;
    if (fifo_empty !== 1'b1 || word_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL stream_end: empty=%b word_cnt=%0d expected 1/%0d", fifo_empty, word_cnt, exp_cnt());
    end
  endtask

  task automatic test_back_pressure();
    int rd = 0;
    int got = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 18; c++) begin
      push = (c < 8); push_dat = 32'h11 + c;
      #1;
      if (fifo_rd_en) rd++;
      if (c >= 8) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h11) begin
          n_fail++; $display("FAIL bp_hold: m_valid=%b m_data=%h expected 1/00000011", m_valid, m_data);
        end
      end
      tick();
    end
    push = 1'b0;
    n_checks++;
    if (rd != 2) begin
      n_fail++; $display("FAIL bp_reads: issued %0d expected 2", rd);
    end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h11 + got) begin
        n_fail++; $display("FAIL bp_release: m_valid=%b m_data=%h expected 1/%h", m_valid, m_data, 32'h11 + got);
      end
      if (m_valid) begin got++; pops++; end
      tick();
    end
    n_checks++;
    if (got != 8 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: delivered %0d m_valid=%b expected 8/0", got, m_valid);
    end
  endtask

  task automatic test_alternating();
    int pushed = 0;
    int got = 0;
    int rdn = 0;
    int popn = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      push = (pushed < 16) && (fcnt < 4'd8); push_dat = 32'h200 + pushed;
      m_ready = ((cyc % 2) == 0);
      #1;
      n_checks++;
      if (rdn - popn > 2) begin
        n_fail++; $display("FAIL alt_occ: outstanding %0d expected <=2", rdn - popn);
      end
      if (fifo_rd_en) rdn++;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 32'h200 + got) begin
          n_fail++; $display("FAIL alt_data: got %h expected %h", m_data, 32'h200 + got);
        end
        got++; pops++; popn++;
      end
      if (push) pushed++;
      tick();
    end
    push = 1'b0;
    m_ready = 1'b1;
    n_checks++;
    if (got != 16) begin
      n_fail++; $display("FAIL alt_timeout: delivered %0d expected 16", got);
    end
  endtask

  task automatic test_flush();
    int got = 0;
    m_ready = 1'b0;
    tick();
    push = 1'b1; push_dat = 32'h31;
    tick();
    push_dat = 32'h32;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL flush_rd1: rd_en=%b expected 1", fifo_rd_en);
    end
    tick();
    push_dat = 32'h33;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL flush_rd2: rd_en=%b expected 1", fifo_rd_en);
    end
    tick();
    push = 1'b0; flush = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h31 || fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: m_valid=%b m_data=%h rd_en=%b expected 1/00000031/0", m_valid, m_data, fifo_rd_en);
    end
    tick();
    flush = 1'b0; m_ready = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: m_valid=%b expected 0", m_valid);
    end
    for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
      if (cyc != 0) #1;
      if (m_valid) begin
        n_checks++;
        if (m_data !== 32'h33) begin
          n_fail++; $display("FAIL flush_next: got %h expected 00000033", m_data);
        end
        got++; pops++;
      end
      tick();
    end
    n_checks++;
    if (got != 1 || fifo_empty !== 1'b1 || word_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL flush_end: delivered %0d empty=%b word_cnt=%0d expected 1/1/%0d", got, fifo_empty, word_cnt, exp_cnt());
    end
  endtask

  task automatic test_counter_wrap();
    int pushed = 0;
    int got = 0;
    rstn = 1'b0; fclr = 1'b1; m_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1; fclr = 1'b0; pops = 0;
    n_checks++;
    if (word_cnt !== 4'd0) begin
      n_fail++; $display("FAIL cnt_reset: word_cnt=%0d expected 0", word_cnt);
    end
    for (int cyc = 0; cyc < 200 && got < 17; cyc++) begin
      push = (pushed < 17) && (fcnt < 4'd8); push_dat = 32'h300 + pushed;
      #1;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 32'h300 + got) begin
          n_fail++; $display("FAIL wrap_data: got %h expected %h", m_data, 32'h300 + got);
        end
        got++; pops++;
      end
      if (push) pushed++;
      tick();
    end
    push = 1'b0;
    n_checks++;
`ifdef FIFO_RD_STREAM_CNT_EN
    if (got != 17 || word_cnt !== 4'd1) begin
      n_fail++; $display("FAIL cnt_wrap: delivered %0d word_cnt=%0d expected 17/1", got, word_cnt);
    end
`else
    if (got != 17 || word_cnt !== 4'd0) begin
      n_fail++; $display("FAIL cnt_tied: delivered %0d word_cnt=%0d expected 17/0", got, word_cnt);
    end
`endif
  endtask

  initial begin
    rstn = 1'b0; fclr = 1'b1; push = 1'b0; push_dat = '0; flush = 1'b0; m_ready = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_alternating();
    test_flush();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
